seg7_scan_driver: RTL

//  Consumes the 32-bit LED/BCD7 MMIO word (CPU store to 0x40000010) and drives a 4-digit

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/btn_debounce.sv | 58 +++++
 rtl/seg7_scan_driver.sv | 98 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, display bus layout and hex-to-segment decode for the 4-digit scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HALF_W     = 16;

  localparam logic [SEG_W-1:0]  SEG_BLANK = 8'hFF;
  localparam logic [AN_W-1:0]   AN_OFF    = 4'hF;
  localparam logic [WORD_W-1:0] DISP_ADDR = 32'h4000_0010;

  // Board bus {AN[3:0], SEG[7:0]}, all active low; SEG = {dp,g,f,e,d,c,b,a}
  typedef struct packed {
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
  } leds_t;

  localparam leds_t LEDS_DARK = '{an: AN_OFF, seg: SEG_BLANK};

  function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, stability counter and a 1-cycle pulse
// on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic rise
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  // cand tracks the synchronised level; any change restarts the stability count
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] != cand_q) begin
      cand_d = sync_q[1];
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_ACCEPT) begin
        level_d = cand_q;
      end
    end
    rise_d = level_d & ~level_q;
  end

  assign rise = rise_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex display driver fed from the display MMIO word, with
// frame-aligned (tear-free) updates, leading-zero blanking and a button-selected half.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned LZ_BLANK   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_word,
  input  logic        disp_we,
  input  logic        page_btn,
  output logic [11:0] leds
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] pending_q, pending_d;
  logic [WORD_W-1:0] shown_q, shown_d;
  logic              page_q, page_d;
  leds_t             leds_q, leds_d;

  logic              page_rise;
  logic              tick_c;
  logic              frame_end_c;
  logic [HALF_W-1:0] half_c;
  logic [HALF_W-1:0] upper_c;
  logic              blank_c;
  logic [SEG_W-1:0]  seg_c;
  logic [AN_W-1:0]   an_c;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (page_btn),
    .rise    (page_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      shown_q   <= '0;
      page_q    <= 1'b0;
      leds_q    <= LEDS_DARK;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      page_q    <= page_d;
      leds_q    <= leds_d;
    end
  end

  // Scan timing and the double-buffered display word; shown only moves at a frame boundary
  always_comb begin
    tick_c      = (div_cnt_q == DIV_LAST);
    frame_end_c = tick_c && (idx_q == IDX_LAST);
    div_cnt_d   = tick_c ? '0 : div_cnt_q + DIV_W'(1);
    idx_d       = tick_c ? idx_q + IDX_W'(1) : idx_q;
    pending_d   = disp_we ? disp_word : pending_q;
    shown_d     = shown_q;
    if (frame_end_c) begin
      shown_d = disp_we ? disp_word : pending_q;
    end
    page_d = page_q ^ page_rise;
  end

  // Segment pattern for the digit about to be lit, built from post-boundary state
  always_comb begin
    half_c  = page_q ? shown_d[31:16] : shown_d[15:0];
    upper_c = half_c >> {idx_d, 2'b00};
    blank_c = (LZ_BLANK != 0) && (idx_d != '0) && (upper_c == '0);
    seg_c   = blank_c ? SEG_BLANK : hex2seg(upper_c[3:0]);
    if ((idx_d == IDX_LAST) && page_q) begin
      seg_c[SEG_W-1] = 1'b0;
    end
    an_c   = ~(AN_W'(1) << idx_d);
    leds_d = leds_q;
    if (tick_c) begin
      leds_d.an  = an_c;
      leds_d.seg = seg_c;
    end
  end

  assign leds = leds_q;

endmodule
